// File: rtl/time_sequencer_pkg.sv
// Shared definitions for the time sequencer slice.
// Contents:
//   state_t            - editor state, encoding doubles as the edit_field output
//   KEY_*              - bit positions within the active-low key_pulse bus
//   HOUR_MAX_DEFAULT   - default highest hour before wrap
//   MIN_MAX_DEFAULT    - default highest minute/second before wrap
package time_sequencer_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    SET_H = 2'd1,
    SET_M = 2'd2,
    SET_S = 2'd3
  } state_t;

  localparam int KEY_MODE = 0;
  localparam int KEY_INC  = 1;
  localparam int KEY_DEC  = 2;
  localparam int KEY_AUX  = 3;

  localparam int HOUR_MAX_DEFAULT = 23;
  localparam int MIN_MAX_DEFAULT  = 59;

endpackage

// File: rtl/time_sequencer_if.sv
// Bus between the mode controller side and the time sequencer.
// Signals:
//   tick        - advance enable (pulse or held high)
//   select      - 1 = count up, 0 = count down
//   key_pulse   - debounced keys, active-low, one cycle wide
//   hour/minute/second - current time fields
//   edit_field  - 0 = run, 1 = hour, 2 = minute, 3 = second
//   paused      - counting suspended while in run
//   done        - one-cycle pulse when a countdown lands on 00:00:00
// Modports: master drives the controls, slave (the sequencer) drives the time.
interface time_sequencer_if;

  logic       tick;
  logic       select;
  logic [3:0] key_pulse;
  logic [4:0] hour;
  logic [5:0] minute;
  logic [5:0] second;
  logic [1:0] edit_field;
  logic       paused;
  logic       done;

  modport master (
    output tick, select, key_pulse,
    input  hour, minute, second, edit_field, paused, done
  );

  modport slave (
    input  tick, select, key_pulse,
    output hour, minute, second, edit_field, paused, done
  );

endinterface

// File: rtl/time_sequencer_mod_counter.sv
// Modulo-(MAX+1) up/down counter used for each time field.
// Ports:
//   clk, reset - clock and synchronous active-high reset
//   inc, dec   - step up / step down (inc wins if both are high)
//   clear      - force the value to zero (wins over inc/dec)
//   value      - current count, 0..MAX
//   wrap       - high in the cycle a step will roll MAX->0 or 0->MAX;
//                used as the carry/borrow into the next field
module mod_counter #(
  parameter int MAX = 59,
  parameter int W   = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         dec,
  input  logic         clear,
  output logic [W-1:0] value,
  output logic         wrap
);

  localparam logic [W-1:0] TOP = W'(MAX);

  // A clear never produces a carry, so wrap only looks at the step requests.
  assign wrap = !clear && ((inc && value == TOP) || (!inc && dec && value == '0));

  always_ff @(posedge clk) begin
    if (reset)
      value <= '0;
    else if (clear)
      value <= '0;
    else if (inc)
      value <= (value == TOP) ? '0 : value + W'(1);
    else if (dec)
      value <= (value == '0) ? TOP : value - W'(1);
  end

endmodule

// File: rtl/time_sequencer.sv
// HH:MM:SS run/pause/edit sequencer.
// Ports:
//   clk    - system clock
//   reset  - synchronous active-high reset
//   bus    - slave side of time_sequencer_if (tick, select, key_pulse in;
//            hour, minute, second, edit_field, paused, done out)
// Keys are one-hot by priority: the lowest-index active key wins and any key
// activity swallows a coincident tick.
module time_sequencer
  import time_sequencer_pkg::*;
#(
  parameter int HOUR_MAX = HOUR_MAX_DEFAULT,
  parameter int MIN_MAX  = MIN_MAX_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  time_sequencer_if.slave   bus
);

  state_t     state, state_next;
  logic       paused, paused_next;
  logic       done, done_next;
  logic [3:0] key;
  logic       key_mode, key_inc, key_dec, key_aux, key_any;
  logic       count_en, count_up, count_down, at_zero, at_one;
  logic       sec_inc, sec_dec, min_inc, min_dec, hour_inc, hour_dec, clear_all;
  logic       sec_wrap, min_wrap, hour_wrap;
  logic [4:0] hour;
  logic [5:0] minute, second;

  assign key       = ~bus.key_pulse;
  assign key_mode  = key[KEY_MODE];
  assign key_inc   = key[KEY_INC] & ~key[KEY_MODE];
  assign key_dec   = key[KEY_DEC] & ~key[KEY_INC] & ~key[KEY_MODE];
  assign key_aux   = key[KEY_AUX] & ~key[KEY_DEC] & ~key[KEY_INC] & ~key[KEY_MODE];
  assign key_any   = |key;

  assign at_zero   = (hour == '0) && (minute == '0) && (second == '0);
  assign at_one    = (hour == '0) && (minute == '0) && (second == 6'd1);

  // A countdown sitting at 00:00:00 simply stops instead of borrowing round.
  assign count_en   = (state == RUN) && !paused && bus.tick && !key_any;
  assign count_up   = count_en && bus.select;
  assign count_down = count_en && !bus.select && !at_zero;

  // Edit steps touch one field only; carries come from the counting path.
  assign sec_inc   = ((state == SET_S) && key_inc) || count_up;
  assign sec_dec   = ((state == SET_S) && key_dec) || count_down;
  assign min_inc   = ((state == SET_M) && key_inc) || (count_up && sec_wrap);
  assign min_dec   = ((state == SET_M) && key_dec) || (count_down && sec_wrap);
  assign hour_inc  = ((state == SET_H) && key_inc) || (count_up && sec_wrap && min_wrap);
  assign hour_dec  = ((state == SET_H) && key_dec) || (count_down && sec_wrap && min_wrap);
  assign clear_all = (state != RUN) && key_aux;

  mod_counter #(.MAX(MIN_MAX), .W(6)) u_second (
    .clk(clk), .reset(reset), .inc(sec_inc), .dec(sec_dec), .clear(clear_all),
    .value(second), .wrap(sec_wrap)
  );

  mod_counter #(.MAX(MIN_MAX), .W(6)) u_minute (
    .clk(clk), .reset(reset), .inc(min_inc), .dec(min_dec), .clear(clear_all),
    .value(minute), .wrap(min_wrap)
  );

  mod_counter #(.MAX(HOUR_MAX), .W(5)) u_hour (
    .clk(clk), .reset(reset), .inc(hour_inc), .dec(hour_dec), .clear(clear_all),
    .value(hour), .wrap(hour_wrap)
  );

  // The zero guard means the countdown path can never borrow out of the hours.
  always_comb begin
    if (!reset)
      assert (!(count_down && hour_wrap));
  end

  // State, pause flag and done pulse registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= RUN;
      paused <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_next;
      paused <= paused_next;
      done   <= done_next;
    end
  end

  // Next-state logic. Entering edit pauses the clock and leaving edit does
  // not unpause it. A countdown step from 00:00:01 raises done and pauses.
  always_comb begin
    state_next  = state;
    paused_next = paused;
    done_next   = 1'b0;
    if (key_mode) begin
      case (state)
        RUN: begin
          state_next  = SET_H;
          paused_next = 1'b1;
        end
        SET_H:   state_next = SET_M;
        SET_M:   state_next = SET_S;
        SET_S:   state_next = RUN;
        default: state_next = RUN;
      endcase
    end else if (key_aux && state == RUN) begin
      paused_next = ~paused;
    end
    if (count_down && at_one) begin
      done_next   = 1'b1;
      paused_next = 1'b1;
    end
  end

  assign bus.hour       = hour;
  assign bus.minute     = minute;
  assign bus.second     = second;
  assign bus.edit_field = state;
  assign bus.paused     = paused;
  assign bus.done       = done;

endmodule

// File: tb/tb_time_sequencer.sv
// Directed testbench for time_sequencer: each task drives one scenario and
// checks its own hand-computed expectations.
module tb_time_sequencer;
  import time_sequencer_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  time_sequencer_if bus ();

  time_sequencer dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  function automatic logic [16:0] hms(input int h, input int m, input int s);
    return {5'(h), 6'(m), 6'(s)};
  endfunction

  // Advance one clock and settle just after the edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input int idx);
    bus.key_pulse      = 4'hF;
    bus.key_pulse[idx] = 1'b0;
    cycle();
    bus.key_pulse = 4'hF;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  // Load a time from RUN through the editor; optionally stay in SET_S.
  task automatic preload(input int h, input int m, input int s, input bit to_run);
    press(KEY_MODE);
    press(KEY_AUX);
    repeat (h) press(KEY_INC);
    press(KEY_MODE);
    repeat (m) press(KEY_INC);
    press(KEY_MODE);
    repeat (s) press(KEY_INC);
    if (to_run) press(KEY_MODE);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cycle();
    cycle();
    total++;
    if ({bus.hour, bus.minute, bus.second} !== hms(0, 0, 0)) begin
      bad++;
      $display("[TB] FAIL reset_time got=%0d:%0d:%0d want=0:0:0", bus.hour, bus.minute, bus.second);
    end
    total++;
    if (bus.edit_field !== 2'd0) begin
      bad++;
      $display("[TB] FAIL reset_edit got=%0d want=0", bus.edit_field);
    end
    total++;
    if (bus.paused !== 1'b0 || bus.done !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_flags got paused=%0b done=%0b want 0 0", bus.paused, bus.done);
    end
    reset = 1'b0;
  endtask

  task automatic test_count_up();
    bit done_seen = 1'b0;
    do_reset();
    bus.select = 1'b1;
    repeat (60) begin
      bus.tick = 1'b1;
      cycle();
      bus.tick = 1'b0;
      if (bus.done) done_seen = 1'b1;
      cycle();
      if (bus.done) done_seen = 1'b1;
    end
    total++;
    if ({bus.hour, bus.minute, bus.second} !== hms(0, 1, 0)) begin
      bad++;
      $display("[TB] FAIL count_up_time got=%0d:%0d:%0d want=0:1:0", bus.hour, bus.minute, bus.second);
    end
    total++;
    if (done_seen !== 1'b0) begin
      bad++;
      $display("[TB] FAIL count_up_done got=%0b want=0", done_seen);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    preload(0, 59, 58, 1'b1);
    press(KEY_AUX);
    total++;
    if (bus.paused !== 1'b0) begin
      bad++;
      $display("[TB] FAIL b2b_unpause got=%0b want=0", bus.paused);
    end
    bus.select = 1'b1;
    bus.tick   = 1'b1;
    cycle();
    total++;
    if ({bus.hour, bus.minute, bus.second} !== hms(0, 59, 59)) begin
      bad++;
      $display("[TB] FAIL b2b_first got=%0d:%0d:%0d want=0:59:59", bus.hour, bus.minute, bus.second);
    end
    cycle();
    bus.tick = 1'b0;
    total++;
    if ({bus.hour, bus.minute, bus.second} !== hms(1, 0, 0)) begin
      bad++;
      $display("[TB] FAIL b2b_carry got=%0d:%0d:%0d want=1:0:0", bus.hour, bus.minute, bus.second);
    end
  endtask

  task automatic test_wrap_day();
    do_reset();
    preload(23, 59, 59, 1'b1);
    total++;
    if ({bus.hour, bus.minute, bus.second} !== hms(23, 59, 59)) begin
      bad++;
      $display("[TB] FAIL wrap_preload got=%0d:%0d:%0d want=23:59:59", bus.hour, bus.minute, bus.second);
    end
    total++;
    if (bus.edit_field !== 2'd0 || bus.paused !== 1'b1) begin
      bad++;
      $display("[TB] FAIL wrap_state got edit=%0d paused=%0b want edit=0 paused=1", bus.edit_field, bus.paused);
    end
    press(KEY_AUX);
    bus.select = 1'b1;
    bus.tick   = 1'b1;
    cycle();
    bus.tick = 1'b0;
    total++;
    if ({bus.hour, bus.minute, bus.second} !== hms(0, 0, 0) || bus.done !== 1'b0) begin
      bad++;
      $display("[TB] FAIL wrap_day got=%0d:%0d:%0d done=%0b want=0:0:0 done=0", bus.hour, bus.minute, bus.second, bus.done);
    end
  endtask

  task automatic test_countdown();
    do_reset();
    preload(0, 0, 2, 1'b1);
    press(KEY_AUX);
    bus.select = 1'b0;
    bus.tick   = 1'b1;
    cycle();
    total++;
    if ({bus.hour, bus.minute, bus.second} !== hms(0, 0, 1) || bus.done !== 1'b0) begin
      bad++;
      $display("[TB] FAIL down_step1 got=%0d:%0d:%0d done=%0b want=0:0:1 done=0", bus.hour, bus.minute, bus.second, bus.done);
    end
    cycle();
    total++;
    if ({bus.hour, bus.minute, bus.second} !== hms(0, 0, 0) || bus.done !== 1'b1) begin
      bad++;
      $display("[TB] FAIL down_step2 got=%0d:%0d:%0d done=%0b want=0:0:0 done=1", bus.hour, bus.minute, bus.second, bus.done);
    end
    total++;
    if (bus.paused !== 1'b1) begin
      bad++;
      $display("[TB] FAIL down_paused got=%0b want=1", bus.paused);
    end
    cycle();
    total++;
    if ({bus.hour, bus.minute, bus.second} !== hms(0, 0, 0) || bus.done !== 1'b0) begin
      bad++;
      $display("[TB] FAIL down_hold1 got=%0d:%0d:%0d done=%0b want=0:0:0 done=0", bus.hour, bus.minute, bus.second, bus.done);
    end
    cycle();
    bus.tick = 1'b0;
    total++;
    if ({bus.hour, bus.minute, bus.second} !== hms(0, 0, 0) || bus.done !== 1'b0) begin
      bad++;
      $display("[TB] FAIL down_hold2 got=%0d:%0d:%0d done=%0b want=0:0:0 done=0", bus.hour, bus.minute, bus.second, bus.done);
    end
  endtask

  task automatic test_hold_zero();
    do_reset();
    bus.select = 1'b0;
    bus.tick   = 1'b1;
    cycle();
    bus.tick = 1'b0;
    total++;
    if ({bus.hour, bus.minute, bus.second} !== hms(0, 0, 0) || bus.done !== 1'b0 || bus.paused !== 1'b0) begin
      bad++;
      $display("[TB] FAIL zero_hold got=%0d:%0d:%0d done=%0b paused=%0b want=0:0:0 done=0 paused=0",
               bus.hour, bus.minute, bus.second, bus.done, bus.paused);
    end
  endtask

  task automatic test_set_minute();
    do_reset();
    press(KEY_MODE);
    press(KEY_MODE);
    repeat (59) press(KEY_INC);
    total++;
    if (bus.edit_field !== 2'd2 || {bus.hour, bus.minute, bus.second} !== hms(0, 59, 0)) begin
      bad++;
      $display("[TB] FAIL setm_load got edit=%0d %0d:%0d:%0d want edit=2 0:59:0", bus.edit_field, bus.hour, bus.minute, bus.second);
    end
    press(KEY_INC);
    total++;
    if ({bus.hour, bus.minute, bus.second} !== hms(0, 0, 0)) begin
      bad++;
      $display("[TB] FAIL setm_inc_wrap got=%0d:%0d:%0d want=0:0:0", bus.hour, bus.minute, bus.second);
    end
    press(KEY_DEC);
    total++;
    if ({bus.hour, bus.minute, bus.second} !== hms(0, 59, 0)) begin
      bad++;
      $display("[TB] FAIL setm_dec_wrap got=%0d:%0d:%0d want=0:59:0", bus.hour, bus.minute, bus.second);
    end
    // INC and DEC together: INC has the lower index and wins.
    bus.key_pulse = 4'b1001;
    cycle();
    bus.key_pulse = 4'hF;
    total++;
    if ({bus.hour, bus.minute, bus.second} !== hms(0, 0, 0)) begin
      bad++;
      $display("[TB] FAIL setm_priority got=%0d:%0d:%0d want=0:0:0", bus.hour, bus.minute, bus.second);
    end
    press(KEY_DEC);
    press(KEY_AUX);
    total++;
    if ({bus.hour, bus.minute, bus.second} !== hms(0, 0, 0) || bus.edit_field !== 2'd2) begin
      bad++;
      $display("[TB] FAIL setm_clear got=%0d:%0d:%0d edit=%0d want=0:0:0 edit=2", bus.hour, bus.minute, bus.second, bus.edit_field);
    end
  endtask

  task automatic test_mode_tick();
    do_reset();
    bus.select    = 1'b1;
    bus.key_pulse = 4'b1110;
    bus.tick      = 1'b1;
    cycle();
    bus.key_pulse = 4'hF;
    bus.tick      = 1'b0;
    total++;
    if (bus.edit_field !== 2'd1 || bus.paused !== 1'b1) begin
      bad++;
      $display("[TB] FAIL mode_tick_state got edit=%0d paused=%0b want edit=1 paused=1", bus.edit_field, bus.paused);
    end
    total++;
    if ({bus.hour, bus.minute, bus.second} !== hms(0, 0, 0)) begin
      bad++;
      $display("[TB] FAIL mode_tick_time got=%0d:%0d:%0d want=0:0:0", bus.hour, bus.minute, bus.second);
    end
    // An INC key in RUN does nothing but still swallows the tick.
    do_reset();
    bus.key_pulse = 4'b1101;
    bus.tick      = 1'b1;
    cycle();
    bus.key_pulse = 4'hF;
    bus.tick      = 1'b0;
    total++;
    if ({bus.hour, bus.minute, bus.second} !== hms(0, 0, 0) || bus.edit_field !== 2'd0) begin
      bad++;
      $display("[TB] FAIL run_inc_tick got=%0d:%0d:%0d edit=%0d want=0:0:0 edit=0", bus.hour, bus.minute, bus.second, bus.edit_field);
    end
  endtask

  task automatic test_reset_mid_edit();
    do_reset();
    preload(12, 34, 56, 1'b0);
    total++;
    if (bus.edit_field !== 2'd3 || {bus.hour, bus.minute, bus.second} !== hms(12, 34, 56)) begin
      bad++;
      $display("[TB] FAIL edit_load got edit=%0d %0d:%0d:%0d want edit=3 12:34:56", bus.edit_field, bus.hour, bus.minute, bus.second);
    end
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    total++;
    if ({bus.hour, bus.minute, bus.second} !== hms(0, 0, 0) || bus.edit_field !== 2'd0 || bus.paused !== 1'b0) begin
      bad++;
      $display("[TB] FAIL edit_reset got=%0d:%0d:%0d edit=%0d paused=%0b want=0:0:0 edit=0 paused=0",
               bus.hour, bus.minute, bus.second, bus.edit_field, bus.paused);
    end
  endtask

  initial begin
    reset         = 1'b1;
    bus.tick      = 1'b0;
    bus.select    = 1'b1;
    bus.key_pulse = 4'hF;
    $display("[TB] starting time_sequencer tests");
    test_reset();
    test_count_up();
    test_back_to_back();
    test_wrap_day();
    test_countdown();
    test_hold_zero();
    test_set_minute();
    test_mode_tick();
    test_reset_mid_edit();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/time_sequencer.md
# time_sequencer

Time-of-day / countdown controller placed directly after `mode_control`. Consumes its `tick` and `select` outputs plus the debounced key pulses, sequences an HH:MM:SS counter through run, pause and field-edit states, and drives the time fields and edit-field indicator to the display logic. It owns all time state; `mode_control` only supplies the rate and direction.

## Interface
Parameters
- `HOUR_MAX`, 23, highest hour value before wrap
- `MIN_MAX`, 59, highest minute/second value before wrap

Ports
- `clk`  input  1  system clock; the only clock
- `reset`  input  1  synchronous, active-high reset (the `reset` output of `mode_control`)
- `tick`  input  1  advance enable; may be a 1-cycle pulse or held high (fast mode)
- `select`  input  1  1 = count up (clock), 0 = count down (timer)
- `key_pulse`  input  4  debounced key pulses, active-low, one cycle wide
- `hour`  output  5  current hours, binary 0..HOUR_MAX
- `minute`  output  6  current minutes, binary 0..MIN_MAX
- `second`  output  6  current seconds, binary 0..MIN_MAX
- `edit_field`  output  2  0 = none (run), 1 = hour, 2 = minute, 3 = second
- `paused`  output  1  1 while counting is suspended in RUN
- `done`  output  1  one-cycle pulse when countdown reaches 00:00:00

## Operation
- States: RUN, SET_H, SET_M, SET_S. `edit_field` equals state encoding (RUN=0).
- `key_pulse[0]` low: state advance RUN→SET_H→SET_M→SET_S→RUN. Entering SET_H forces `paused`=1; returning to RUN keeps `paused`=1.
- `key_pulse[1]` low: in SET_x, increment selected field, wrap MAX→0, no carry into neighbours. In RUN: no effect.
- `key_pulse[2]` low: in SET_x, decrement selected field, wrap 0→MAX, no borrow. In RUN: no effect.
- `key_pulse[3]` low: in RUN, toggle `paused`; in SET_x, clear all three fields to 0.
- Several keys low in one cycle: lowest index acts, others ignored. All four low never reaches this block (that pattern is reset at `mode_control`).
- Counting: only in RUN with `paused`=0 and `tick`=1; one step per cycle `tick` is high.
- `select`=1: second+1; second MAX→0 carries to minute; minute MAX→0 carries to hour; 23:59:59→00:00:00.
- `select`=0: second−1 with borrow chain; at 00:00:00 no step, value holds. Step that lands on 00:00:00 asserts `done` for exactly that cycle’s result (one cycle); sets `paused`=1.
- `select` change mid-run takes effect on the next counted tick; no state change.
- Key event and `tick` in the same cycle: key acts, tick ignored.

## Timing
- All outputs registered; field/state updates visible the cycle after the qualifying `tick` or key pulse.
- `done` asserted in the same cycle the fields first read 00:00:00; deasserted next cycle.
- Reset (any cycle, including mid-edit or mid-carry): hour=minute=second=0, state RUN, `edit_field`=0, `paused`=0, `done`=0, effective the cycle after `reset` is sampled high; held while high.
- Held-high `tick`: one step per clock, carries resolved in the same cycle (no multi-cycle ripple).

## Structure
- Shared package: state encoding constants (RUN/SET_H/SET_M/SET_S), key index constants (KEY_MODE=0, KEY_INC=1, KEY_DEC=2, KEY_AUX=3), default HOUR_MAX/MIN_MAX.
- One sub-module `mod_counter`: parameterised modulus, inputs inc/dec/clear, outputs value and wrap (carry/borrow) flag; instantiated three times. FSM, pause flag and `done` generation live in the top.

## Test plan
- Reset, then 60 tick pulses with `select`=1 → 00:01:00, `done` never high.
- Preload 23:59:59 via SET mode, RUN, unpause, one tick → 00:00:00, no `done`.
- Preload 00:00:02, `select`=0, `tick` held high 4 cycles → 00:00:01, 00:00:00 with `done` one cycle, then holds 00:00:00, `paused`=1.
- SET_M at 00:59:00: KEY_INC → 00:00:00 (no hour carry); KEY_DEC → 00:59:00; KEY_AUX → all zero.
- KEY_MODE and tick same cycle in RUN → state SET_H, `paused`=1, time unchanged.
- Assert `reset` while in SET_S at 12:34:56 → next cycle 00:00:00, `edit_field`=0, `paused`=0.
